// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared AXI4-Lite response codes, widths and responder FSM states.
package axi4_lite_pkg;
    localparam int AXI_ADDR_W = 28;
    localparam int AXI_DATA_W = 64;
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;
    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_ADDR,
        WR_HAVE_DATA,
        WR_RESP
    } wr_state_e;
    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_e;
endpackage

// File: rtl/axi4_lite_addr_decode.sv
// axi4_lite_addr_decode: maps a byte address to a word index and response code.
module axi4_lite_addr_decode
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W      = AXI_ADDR_W,
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output resp_e             resp
);
    assign idx  = addr[3 +: IDX_W];
    // Upper bits are checked rather than dropped so high addresses never alias.
    assign resp = (addr[2:0] != 3'd0) ? SLVERR :
                  (|addr[ADDR_W-1:IDX_W+3]) ? DECERR : OKAY;
endmodule

// File: rtl/axi4_lite_mem_responder.sv
// axi4_lite_mem_responder: AXI4-Lite responder over an on-chip 64-bit word array.
// Handshake counters are built only when AXI4_LITE_MEM_RESPONDER_STATS_EN is defined.
module axi4_lite_mem_responder
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W      = AXI_ADDR_W,
    parameter int DATA_W      = AXI_DATA_W,
    parameter int DEPTH_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic [2:0]        awprot_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [7:0]        wstrb_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [1:0]        bresp_o,
    output logic              bvalid_o,
    input  logic              bready_i,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic [2:0]        arprot_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [31:0]       wr_count_o,
    output logic [31:0]       rd_count_o,
    output logic [15:0]       err_count_o
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    wr_state_e         wr_st, wr_next;
    rd_state_e         rd_st, rd_next;
    logic [ADDR_W-1:0] awaddr_q, waddr;
    logic [DATA_W-1:0] wdata_q, wdata;
    logic [7:0]        wstrb_q, wstrb;
    logic [IDX_W-1:0]  widx, ridx;
    resp_e             wresp, rresp;
    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic              unused_prot;

    assign unused_prot = ^{awprot_i, arprot_i};

    // Readies are gated by reset so they read 0 while reset is held.
    assign awready_o = !reset_i && (wr_st == WR_IDLE || wr_st == WR_HAVE_DATA);
    assign wready_o  = !reset_i && (wr_st == WR_IDLE || wr_st == WR_HAVE_ADDR);
    assign bvalid_o  = wr_st == WR_RESP;
    assign arready_o = !reset_i && rd_st == RD_IDLE;
    assign rvalid_o  = rd_st == RD_RESP;

    assign aw_hs  = awvalid_i && awready_o;
    assign w_hs   = wvalid_i && wready_o;
    assign b_hs   = bvalid_o && bready_i;
    assign ar_hs  = arvalid_i && arready_o;
    assign r_hs   = rvalid_o && rready_i;
    assign commit = (aw_hs || wr_st == WR_HAVE_ADDR) && (w_hs || wr_st == WR_HAVE_DATA);

    assign waddr = aw_hs ? awaddr_i : awaddr_q;
    assign wdata = w_hs ? wdata_i : wdata_q;
    assign wstrb = w_hs ? wstrb_i : wstrb_q;

    axi4_lite_addr_decode #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH_WORDS)) u_aw_dec (
        .addr(waddr),
        .idx (widx),
        .resp(wresp)
    );

    axi4_lite_addr_decode #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH_WORDS)) u_ar_dec (
        .addr(araddr_i),
        .idx (ridx),
        .resp(rresp)
    );

    always_comb begin
        wr_next = wr_st;
        wr_next = commit ? WR_RESP : b_hs ? WR_IDLE : aw_hs ? WR_HAVE_ADDR : w_hs ? WR_HAVE_DATA : wr_st;
    end

    always_comb begin
        rd_next = rd_st;
        rd_next = ar_hs ? RD_RESP : r_hs ? RD_IDLE : rd_st;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_st    <= WR_IDLE;
            rd_st    <= RD_IDLE;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_o  <= '0;
            rdata_o  <= '0;
            rresp_o  <= '0;
        end else begin
            wr_st <= wr_next;
            rd_st <= rd_next;
            if (aw_hs) awaddr_q <= awaddr_i;
            if (w_hs) begin
                wdata_q <= wdata_i;
                wstrb_q <= wstrb_i;
            end
            if (commit) bresp_o <= wresp;
            // Array is sampled before this edge's commit lands, so a colliding read sees old data.
            if (ar_hs) begin
                rdata_o <= (rresp == OKAY) ? mem[ridx] : '0;
                rresp_o <= rresp;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (commit && wresp == OKAY)
            for (int k = 0; k < DATA_W / 8; k++)
                if (wstrb[k]) mem[widx][8*k +: 8] <= wdata[8*k +: 8];
    end

`ifdef AXI4_LITE_MEM_RESPONDER_STATS_EN
    logic [32:0] wr_sum, rd_sum;
    logic [16:0] err_sum;

    assign wr_sum  = {1'b0, wr_count_o} + 33'(b_hs);
    assign rd_sum  = {1'b0, rd_count_o} + 33'(r_hs);
    assign err_sum = {1'b0, err_count_o} + 17'(b_hs && bresp_o != OKAY) + 17'(r_hs && rresp_o != OKAY);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_count_o  <= '0;
            rd_count_o  <= '0;
            err_count_o <= '0;
        end else begin
            wr_count_o  <= wr_sum[32] ? '1 : wr_sum[31:0];
            rd_count_o  <= rd_sum[32] ? '1 : rd_sum[31:0];
            err_count_o <= err_sum[16] ? '1 : err_sum[15:0];
        end
    end
`else
    assign wr_count_o  = '0;
    assign rd_count_o  = '0;
    assign err_count_o = '0;
`endif
endmodule

// File: doc/axi4_lite_mem_responder.md
Name: axi4_lite_mem_responder

Overview:
AXI4-Lite subordinate (responder) backed by an on-chip word array. It is the target end for the AXI4-Lite traffic generator and other initiators in bring-up and simulation. It accepts 28-bit-address, 64-bit-data transactions, applies byte strobes, and returns OKAY/SLVERR/DECERR. Read and write channels run independently, with one outstanding transaction per direction.

Parameters:
ADDR_W, 28, AXI address width.
DATA_W, 64, data width; fixed at 64, so 8 strobe bits.
DEPTH_WORDS, 256, number of 64-bit words; must be a power of 2; valid byte range is [0, DEPTH_WORDS*8).

Ports:
clk_i  in  1  clock; all logic on rising edge
reset_i  in  1  asynchronous, active-high reset
awaddr_i  in  ADDR_W  write address
awprot_i  in  3  write protection; ignored
awvalid_i  in  1  write address valid
awready_o  out  1  write address ready
wdata_i  in  DATA_W  write data
wstrb_i  in  8  write byte strobes
wvalid_i  in  1  write data valid
wready_o  out  1  write data ready
bresp_o  out  2  write response
bvalid_o  out  1  write response valid
bready_i  in  1  write response ready
araddr_i  in  ADDR_W  read address
arprot_i  in  3  read protection; ignored
arvalid_i  in  1  read address valid
arready_o  out  1  read address ready
rdata_o  out  DATA_W  read data
rresp_o  out  2  read response
rvalid_o  out  1  read data valid
rready_i  in  1  read data ready
wr_count_o  out  32  accepted writes (stats option)
rd_count_o  out  32  accepted reads (stats option)
err_count_o  out  16  non-OKAY responses (stats option)

Behaviour:
- Reset: reset_i high immediately forces both FSMs to idle and every output to 0, including all readies. The memory array is not reset; its contents are undefined at power-on and preserved across later resets.
- Write FSM states:
  - WR_IDLE: awready_o=1, wready_o=1.
  - WR_HAVE_ADDR: awready_o=0, wready_o=1.
  - WR_HAVE_DATA: awready_o=1, wready_o=0.
  - WR_RESP: both readies 0, bvalid_o=1.
- Write transitions:
  - AW and W handshake in the same cycle → WR_RESP.
  - AW only → WR_HAVE_ADDR. W only → WR_HAVE_DATA.
  - The missing half arriving → WR_RESP.
  - Address and data/strobe are captured at their respective handshakes.
- Write commit: happens on the edge where the second half is captured. bvalid_o rises the next cycle, so latency is 1 cycle after the last handshake.
- Write byte enables: byte lane k is written only when wstrb_i[k]=1. wstrb_i=0 is legal, writes nothing and returns OKAY.
- WR_RESP: bvalid_o and bresp_o are held stable until bready_i=1, then the FSM returns to WR_IDLE. Readies reassert the following cycle (no same-cycle reuse).
- Response decode, identical for reads and writes:
  - addr[2:0]≠0 → SLVERR (2'b10).
  - Otherwise addr ≥ DEPTH_WORDS*8 → DECERR (2'b11).
  - Otherwise OKAY (2'b00); word index = addr[3 +: log2(DEPTH_WORDS)].
  - On any error the write is dropped and the read returns rdata_o=0.
- Read FSM states:
  - RD_IDLE: arready_o=1.
  - On AR handshake the array word is sampled on that edge → RD_RESP.
  - RD_RESP: arready_o=0, rvalid_o=1. rdata_o/rresp_o are held stable until rready_i=1, then → RD_IDLE.
  - Read latency is 1 cycle from the AR handshake to rvalid_o.
- Simultaneous read and write to the same word: an AR handshake on the same edge as a write commit returns the OLD data. A later read returns the new data.
- Read and write paths never stall each other.
- Address bits above the decoded range are not aliased; they produce DECERR.
- Reset asserted mid-transaction: any pending response is abandoned. If the write commit edge has not occurred, the array is left untouched.

Optional Feature:
AXI4_LITE_MEM_RESPONDER_STATS_EN.
- Defined:
  - wr_count_o increments on every B handshake.
  - rd_count_o increments on every R handshake.
  - err_count_o increments on each B or R handshake with resp≠OKAY; a B and R error in the same cycle add 2.
  - All counters saturate at all-ones and clear on reset.
- Undefined: the three ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - resp typedef: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - AXI4-Lite width constants (28 address, 64 data).
  - The write and read FSM state enums.
- One sub-module, axi4_lite_addr_decode: combinational; takes the address and produces the word index and resp code. It is instanced twice, once for AW and once for AR.

Test Plan:
1. Write 0xDEADBEEF_01234567 at 0x10 with wstrb=0xFF, then read 0x10 → bresp=00, rdata=0xDEADBEEF_01234567, rresp=00, each response exactly 1 cycle after its handshake.
2. Write 0x0 to 0x18 with wstrb=0xFF, then 0xFFFF…FF with wstrb=0x0F; read → 0x00000000_FFFFFFFF.
3. Issue W 3 cycles before AW, and separately AW 3 cycles before W → single commit; bvalid 1 cycle after the later handshake; awready/wready follow the state table.
4. Write to 0x804 → SLVERR. Read 0x800 with DEPTH_WORDS=256 → DECERR, rdata=0. Memory word 0 is unchanged.
5. Hold bready/rready low for 5 cycles → bvalid/rvalid, resp and rdata stable for all 5; readies stay 0; completion on release.
6. Same-edge AR and write commit to 0x20 (old 0x1, new 0x2) → read returns 0x1; a next read returns 0x2. Assert reset_i while in RD_RESP → rvalid_o drops immediately, arready_o=1 once reset is released. With the stats macro, counts match the handshakes.
